// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath: frame constants, tx state encoding
// and helpers that derive baud-counter sizing from the clock and line rates.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Minimum of one bit so a rejected configuration still elaborates far enough to report.
    function automatic int calc_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data; pushes when full and pops
// when empty are ignored, so callers may drive push/pop unconditionally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes from the core queue in sync_fifo and are
// serialised LSB first onto txd, with a sticky flag for bytes dropped while full.
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (high); pops the next byte directly if one is queued
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 24_000_000,
    parameter int BAUD   = 115_200,
    parameter int DEPTH  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       overflow
);

    localparam int CPB = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = calc_cnt_width(CPB);
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [AW:0]   FCNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FCNT_FULL = (AW+1)'(DEPTH);

    generate
        if (CPB < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLK_HZ / BAUD must be at least 2");
        end
    endgenerate

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;
    logic           tx_ready_q, tx_ready_d;
    logic           overflow_q, overflow_d;

    logic           pop_req;
    logic           bit_end;
    logic           push_ok;
    logic [7:0]     fifo_dout;
    logic           fifo_full, fifo_empty;
    logic [AW:0]    fifo_count, count_nxt;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tx_start),
        .pop     (pop_req),
        .din     (tx_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
                    else                       bit_idx_d = bit_idx_q + BIT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop_req = 1'b1;
                        shift_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the registered state, so txd lags state_q by one clock.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Fullness is judged on the pre-edge count, so a pop cannot rescue a push to a full FIFO.
    always_comb begin
        push_ok   = tx_start & ~fifo_full;
        count_nxt = fifo_count;
        case ({push_ok, pop_req})
            2'b10:   count_nxt = fifo_count + FCNT_ONE;
            2'b01:   count_nxt = fifo_count - FCNT_ONE;
            default: count_nxt = fifo_count;
        endcase
        tx_ready_d = (count_nxt != FCNT_FULL);
        overflow_d = overflow_q | (tx_start & fifo_full);
        busy_d     = (state_q != ST_IDLE) || (fifo_count != '0);
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign tx_ready = tx_ready_q;
    assign overflow = overflow_q;

endmodule
